// File: rtl/seg7_scan_2d.sv
// Two-digit multiplexed 7-segment driver with frame-latched BCD, leading-zero
// blanking and a stretched carry indicator on the units decimal point.
module seg7_scan_2d #(
    parameter int SCAN_DIV = 1000,
    parameter int DP_LEN   = 5000000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic [7:0] BCD,
    input  logic       TC,
    input  logic       BLANK_LZ,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [1:0] AN
);

    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int DC_W = $clog2(DP_LEN + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DP_LEN);

    logic [SC_W-1:0] sc_q, sc_d;
    logic            dig_q, dig_d;
    logic [7:0]      dl_q, dl_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [1:0]      an_q, an_d;
    logic [3:0]      nib;
    logic            wrap;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    always_ff @(posedge CP) begin
        if (CR) begin
            sc_q  <= '0;
            dig_q <= 1'b0;
            dl_q  <= 8'h00;
            dc_q  <= '0;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= 2'b11;
        end else begin
            sc_q  <= sc_d;
            dig_q <= dig_d;
            dl_q  <= dl_d;
            dc_q  <= dc_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    // Latch refreshes only when the tens slot hands back to units, so a frame never tears.
    always_comb begin
        wrap  = (sc_q == SC_LAST);
        sc_d  = '0;
        dig_d = 1'b0;
        dl_d  = BCD;
        if (EN) begin
            sc_d  = wrap ? '0 : sc_q + SC_W'(1);
            dig_d = wrap ? ~dig_q : dig_q;
            dl_d  = (wrap && dig_q) ? BCD : dl_q;
        end
        if (TC)
            dc_d = DC_LOAD;
        else if (dc_q != '0)
            dc_d = dc_q - DC_W'(1);
        else
            dc_d = dc_q;
    end

    always_comb begin
        nib   = dig_q ? dl_q[7:4] : dl_q[3:0];
        seg_d = seg_decode(nib);
        if (dig_q && BLANK_LZ && (dl_q[7:4] == 4'h0))
            seg_d = 7'h7F;
        if (!EN)
            an_d = 2'b11;
        else
            an_d = dig_q ? 2'b01 : 2'b10;
        dp_d = !((dc_q != '0) && EN && !dig_q);
    end

    assign SEG = seg_q;
    assign DP  = dp_q;
    assign AN  = an_q;

endmodule

// File: doc/seg7_scan_2d.md
SEG7_SCAN_2D -- requirements
Module: seg7_scan_2d

Interface
REQ-001 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles each digit is displayed per scan slot (legal range 2..65535).
REQ-002 Parameter DP_LEN, default 5000000, SHALL set the clock cycles the carry indicator stays lit after a TC pulse (legal range 1..2^24-1).
REQ-003 CP  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 CR  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 EN  input  1  SHALL be display enable, active-high.
REQ-006 BCD  input  8  SHALL carry two BCD digits from the upstream counter: [7:4] tens, [3:0] units.
REQ-007 TC  input  1  SHALL be the upstream carry/borrow pulse, active-high, one or more cycles wide.
REQ-008 BLANK_LZ  input  1  SHALL enable leading-zero blanking of the tens digit when high.
REQ-009 SEG  output  7  SHALL drive segments active-low, ordered {g,f,e,d,c,b,a}.
REQ-010 DP  output  1  SHALL drive the decimal point, active-low.
REQ-011 AN  output  2  SHALL drive digit anodes, active-low: 2'b10 selects units, 2'b01 selects tens, 2'b11 selects none.

Function
REQ-012 Internal state SHALL be: scan counter sc (0..SCAN_DIV-1), digit select dig (0 = units, 1 = tens), display latch dl[7:0], and DP stretch counter dc.
REQ-013 With EN=1, sc SHALL increment each cycle; at sc==SCAN_DIV-1 it SHALL wrap to 0 and dig SHALL toggle in the same cycle.
REQ-014 dl SHALL load BCD only in the cycle where dig toggles 1->0 (frame boundary), so both digits of a frame always come from one sample (no tearing).
REQ-015 With EN=0: sc=0, dig=0, dl SHALL load BCD every cycle (transparent), and AN SHALL be 2'b11.
REQ-016 SEG, DP and AN SHALL be registered outputs, reflecting dig/dl/dc state with exactly one cycle of latency.
REQ-017 Decode (active-low, hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-018 A nibble of A-F SHALL display a dash, SEG=3F (only g lit).
REQ-019 With BLANK_LZ=1 and dl[7:4]==0, the tens slot SHALL output SEG=7F while AN still selects tens; the units digit is never blanked.
REQ-020 A cycle with TC=1 SHALL load dc with DP_LEN, regardless of EN; otherwise dc SHALL decrement while nonzero and hold at 0.
REQ-021 TC arriving while dc is nonzero SHALL retrigger the counter back to DP_LEN (no accumulation, no wrap).
REQ-022 DP SHALL be 0 only while dc!=0, EN=1 and the units digit is selected; otherwise DP=1.
REQ-023 sc and dc SHALL be sized to hold their parameter maxima with no overflow.

Reset
REQ-024 CR=1 at a rising edge SHALL force sc=0, dig=0, dl=8'h00, dc=0, SEG=7F, DP=1 and AN=2'b11, overriding EN and TC in that cycle.
REQ-025 CR asserted mid-frame or mid-stretch SHALL abandon the frame or stretch with no residual output.
REQ-026 In the first cycle after CR falls (EN=1), state SHALL be units, dl=00; the next cycle's outputs SHALL be AN=10, SEG=40.

Verification (SCAN_DIV=4, DP_LEN=8)
REQ-027 BCD=8'h37, EN=1, BLANK_LZ=0 -> AN alternates 10/01 every 4 cycles after the first frame boundary, with SEG=78 for units and SEG=30 for tens.
REQ-028 BCD changes 8'h37->8'h42 while tens is displayed -> tens still shows 3 in that frame; the next frame shows units 2 (SEG=24) and tens 4 (SEG=19).
REQ-029 BCD=8'h05, BLANK_LZ=1 -> tens slot SEG=7F with AN=01; units SEG=12. With BLANK_LZ=0 -> tens SEG=40.
REQ-030 One-cycle TC pulse -> DP=0 during units slots for exactly 8 cycles of dc activity (one-cycle output lag); a second TC at dc=3 extends the stretch to 8 cycles from the retrigger.
REQ-031 BCD=8'hA9 -> tens SEG=3F, units SEG=10.
REQ-032 CR pulsed mid-frame while DP is lit -> next cycle SEG=7F, DP=1, AN=11; resumes at units with dl=00.
